// File: rtl/rect_pkg.sv
// Shared types and screen defaults for the rectangle motion sequencer.
`timescale 1ns/1ps
package rect_pkg;

  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned SCREEN_H_DEF = 480;

  typedef logic [9:0] coord_x_t;
  typedef logic [8:0] coord_y_t;

  typedef enum logic [1:0] {
    StWait,
    StCalcX,
    StCalcY,
    StPublish
  } state_e;

endpackage

// File: rtl/axis_bounce.sv
// Single-axis step: move by speed in the current direction, clamp to [0, MAX],
// reverse and flag a hit when an edge is reached or crossed.
`timescale 1ns/1ps
module axis_bounce #(
  parameter int unsigned W   = 10,
  parameter int unsigned MAX = 624
) (
  input  logic [W-1:0] pos,
  input  logic         dir_neg,
  input  logic [3:0]   speed,
  output logic [W-1:0] next_pos,
  output logic         next_dir_neg,
  output logic         hit
);

  // One extra bit so both undershoot below zero and overshoot past MAX stay visible.
  localparam logic signed [W:0] MaxS  = (W+1)'(MAX);
  localparam logic signed [W:0] ZeroS = '0;

  logic signed [W:0] pos_s;
  logic signed [W:0] spd_s;
  logic signed [W:0] n;

  assign pos_s = $signed({1'b0, pos});
  assign spd_s = $signed({{(W-3){1'b0}}, speed});
  assign n     = dir_neg ? (pos_s - spd_s) : (pos_s + spd_s);

  always_comb begin
    next_pos     = n[W-1:0];
    next_dir_neg = dir_neg;
    hit          = 1'b0;
    if (n >= MaxS) begin
      next_pos     = W'(MAX);
      next_dir_neg = 1'b1;
      hit          = 1'b1;
    end else if (n <= ZeroS) begin
      next_pos     = '0;
      next_dir_neg = 1'b0;
      hit          = 1'b1;
    end
  end

endmodule

// File: rtl/rect_motion_ctrl.sv
// Per-frame motion sequencer for one bouncing rectangle. Bounds are updated atomically.
// Optional macro RECT_MOTION_SPEEDUP_EN: each edge hit bumps that axis speed by 1 (max 15).
`timescale 1ns/1ps
module rect_motion_ctrl
  import rect_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter int unsigned RECT_W   = 16,
  parameter int unsigned RECT_H   = 16,
  parameter int unsigned X_INIT   = 312,
  parameter int unsigned Y_INIT   = 232,
  parameter int unsigned SPEED_X  = 2,
  parameter int unsigned SPEED_Y  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       frame_tick,
  output logic [9:0] x0,
  output logic [9:0] x1,
  output logic [8:0] y0,
  output logic [8:0] y1,
  output logic       hit_x,
  output logic       hit_y,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned XMax = SCREEN_W - RECT_W;
  localparam int unsigned YMax = SCREEN_H - RECT_H;

  state_e   state;
  coord_x_t sh_x;
  coord_y_t sh_y;
  logic     sh_dx_neg, sh_dy_neg;
  logic     sh_hx, sh_hy;
  logic     dx_neg, dy_neg;

  logic [3:0] spd_x, spd_y;
`ifdef RECT_MOTION_SPEEDUP_EN
  logic [3:0] spd_x_q, spd_y_q;
  assign spd_x = spd_x_q;
  assign spd_y = spd_y_q;
`else
  assign spd_x = 4'(SPEED_X);
  assign spd_y = 4'(SPEED_Y);
`endif

  coord_x_t nx;
  coord_y_t ny;
  logic     ndx_neg, ndy_neg;
  logic     nhx, nhy;

  axis_bounce #(
    .W   (10),
    .MAX (XMax)
  ) u_axis_x (
    .pos          (x0),
    .dir_neg      (dx_neg),
    .speed        (spd_x),
    .next_pos     (nx),
    .next_dir_neg (ndx_neg),
    .hit          (nhx)
  );

  axis_bounce #(
    .W   (9),
    .MAX (YMax)
  ) u_axis_y (
    .pos          (y0),
    .dir_neg      (dy_neg),
    .speed        (spd_y),
    .next_pos     (ny),
    .next_dir_neg (ndy_neg),
    .hit          (nhy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StWait;
      x0        <= coord_x_t'(X_INIT);
      x1        <= coord_x_t'(X_INIT + RECT_W - 1);
      y0        <= coord_y_t'(Y_INIT);
      y1        <= coord_y_t'(Y_INIT + RECT_H - 1);
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      sh_x      <= '0;
      sh_y      <= '0;
      sh_dx_neg <= 1'b0;
      sh_dy_neg <= 1'b0;
      sh_hx     <= 1'b0;
      sh_hy     <= 1'b0;
      hit_x     <= 1'b0;
      hit_y     <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
`ifdef RECT_MOTION_SPEEDUP_EN
      spd_x_q   <= 4'(SPEED_X);
      spd_y_q   <= 4'(SPEED_Y);
`endif
    end else begin
      hit_x <= 1'b0;
      hit_y <= 1'b0;
      // A tick landing mid-update is dropped for motion but remembered here.
      if (frame_tick && (state != StWait)) begin
        overrun <= 1'b1;
      end
      unique case (state)
        StWait: begin
          if (frame_tick && enable) begin
            state <= StCalcX;
            busy  <= 1'b1;
          end
        end
        StCalcX: begin
          sh_x      <= nx;
          sh_dx_neg <= ndx_neg;
          sh_hx     <= nhx;
          state     <= StCalcY;
        end
        StCalcY: begin
          sh_y      <= ny;
          sh_dy_neg <= ndy_neg;
          sh_hy     <= nhy;
          state     <= StPublish;
        end
        StPublish: begin
          x0     <= sh_x;
          x1     <= sh_x + coord_x_t'(RECT_W - 1);
          y0     <= sh_y;
          y1     <= sh_y + coord_y_t'(RECT_H - 1);
          dx_neg <= sh_dx_neg;
          dy_neg <= sh_dy_neg;
          hit_x  <= sh_hx;
          hit_y  <= sh_hy;
          busy   <= 1'b0;
          state  <= StWait;
`ifdef RECT_MOTION_SPEEDUP_EN
          if (sh_hx && (spd_x_q != 4'd15)) spd_x_q <= spd_x_q + 4'd1;
          if (sh_hy && (spd_y_q != 4'd15)) spd_y_q <= spd_y_q + 4'd1;
`endif
        end
        default: state <= StWait;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_motion_ctrl.sv
// Self-checking bench: two instances (default and an odd-speed corner-start variant)
// driven with random frame ticks and compared against a per-frame position model.
`timescale 1ns/1ps
module tb_rect_motion_ctrl;

  localparam int RW   = 16;
  localparam int RH   = 16;
  localparam int XMAX = 640 - RW;
  localparam int YMAX = 480 - RH;

  logic clk = 1'b0;
  logic rst, enable, frame_tick;
  logic [1:0][9:0] ox0, ox1;
  logic [1:0][8:0] oy0, oy1;
  logic [1:0]      ohx, ohy, obusy, oov;

  always #5 clk = ~clk;

  rect_motion_ctrl dut_a (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .frame_tick (frame_tick),
    .x0         (ox0[0]),
    .x1         (ox1[0]),
    .y0         (oy0[0]),
    .y1         (oy1[0]),
    .hit_x      (ohx[0]),
    .hit_y      (ohy[0]),
    .busy       (obusy[0]),
    .overrun    (oov[0])
  );

  rect_motion_ctrl #(
    .X_INIT  (620),
    .Y_INIT  (460),
    .SPEED_X (7),
    .SPEED_Y (5)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .frame_tick (frame_tick),
    .x0         (ox0[1]),
    .x1         (ox1[1]),
    .y0         (oy0[1]),
    .y1         (oy1[1]),
    .hit_x      (ohx[1]),
    .hit_y      (ohy[1]),
    .busy       (obusy[1]),
    .overrun    (oov[1])
  );

  int x_init[2]  = '{312, 620};
  int y_init[2]  = '{232, 460};
  int sx_init[2] = '{2, 7};
  int sy_init[2] = '{2, 5};

  int m_x[2], m_y[2], m_dx[2], m_dy[2], m_sx[2], m_sy[2];
  bit m_hx[2], m_hy[2];
  bit m_ov;

  int errors = 0;
  int checks = 0;

  // Reflecting motion on one axis: position stays in [0, mx]; touching or crossing an edge bounces.
  task automatic axis_step(input int p, input int d, input int s, input int mx,
                           output int np, output int nd, output bit h);
    np = p + d * s;
    nd = d;
    h  = 1'b0;
    if (np >= mx) begin
      np = mx; nd = -1; h = 1'b1;
    end else if (np <= 0) begin
      np = 0; nd = 1; h = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_x[i] = x_init[i];  m_y[i] = y_init[i];
      m_dx[i] = 1;         m_dy[i] = 1;
      m_sx[i] = sx_init[i]; m_sy[i] = sy_init[i];
      m_hx[i] = 1'b0;      m_hy[i] = 1'b0;
    end
    m_ov = 1'b0;
  endtask

  task automatic model_move();
    int np, nd;
    bit h;
    for (int i = 0; i < 2; i++) begin
      axis_step(m_x[i], m_dx[i], m_sx[i], XMAX, np, nd, h);
      m_x[i] = np; m_dx[i] = nd; m_hx[i] = h;
      axis_step(m_y[i], m_dy[i], m_sy[i], YMAX, np, nd, h);
      m_y[i] = np; m_dy[i] = nd; m_hy[i] = h;
`ifdef RECT_MOTION_SPEEDUP_EN
      if (m_hx[i] && m_sx[i] < 15) m_sx[i]++;
      if (m_hy[i] && m_sy[i] < 15) m_sy[i]++;
`endif
    end
  endtask

  // One frame: tick, optional second tick one cycle later, optional enable drop mid-update.
  // Checks every cycle from the tick edge until one cycle after the publish edge.
  task automatic run_frame(input bit en, input bit extra, input bit drop);
    logic [37:0] exp_b;
    logic [1:0]  exp_h;
    @(negedge clk);
    enable = en;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = extra;
    if (drop) enable = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin
        frame_tick = 1'b0;
        if (en && extra) m_ov = 1'b1;
      end
      if (c == 4 && en) model_move();
      for (int i = 0; i < 2; i++) begin
        exp_b = {10'(m_x[i]), 10'(m_x[i] + RW - 1), 9'(m_y[i]), 9'(m_y[i] + RH - 1)};
        exp_h = (c == 4 && en) ? {m_hx[i], m_hy[i]} : 2'b00;
        checks++;
        if ({ox0[i], ox1[i], oy0[i], oy1[i]} !== exp_b) begin
          errors++;
          $display("FAIL bounds inst%0d cyc%0d: got x0=%0d x1=%0d y0=%0d y1=%0d want %0d %0d %0d %0d",
                   i, c, ox0[i], ox1[i], oy0[i], oy1[i], exp_b[37:28], exp_b[27:18],
                   exp_b[17:9], exp_b[8:0]);
        end
        checks++;
        if (obusy[i] !== (en && c < 4)) begin
          errors++;
          $display("FAIL busy inst%0d cyc%0d: got %b want %b", i, c, obusy[i], en && c < 4);
        end
        checks++;
        if ({ohx[i], ohy[i]} !== exp_h) begin
          errors++;
          $display("FAIL hits inst%0d cyc%0d: got hx/hy=%b%b want %b", i, c, ohx[i], ohy[i],
                   exp_h);
        end
        checks++;
        if (oov[i] !== m_ov) begin
          errors++;
          $display("FAIL overrun inst%0d cyc%0d: got %b want %b", i, c, oov[i], m_ov);
        end
      end
      if (c < 5) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    checks++;
    if ({ox0[0], ox1[0], oy0[0], oy1[0]} !== {10'd312, 10'd327, 9'd232, 9'd247}) begin
      errors++;
      $display("FAIL reset_bounds: got %0d %0d %0d %0d want 312 327 232 247",
               ox0[0], ox1[0], oy0[0], oy1[0]);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({ohx[i], ohy[i], obusy[i], oov[i]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_flags inst%0d: got hx,hy,busy,ov=%b%b%b%b want 0000",
                 i, ohx[i], ohy[i], obusy[i], oov[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_first_tick();
    run_frame(1'b1, 1'b0, 1'b0);
    checks++;
    if ({ox0[0], ox1[0], oy0[0], oy1[0]} !== {10'd314, 10'd329, 9'd234, 9'd249}) begin
      errors++;
      $display("FAIL first_tick: got %0d %0d %0d %0d want 314 329 234 249",
               ox0[0], ox1[0], oy0[0], oy1[0]);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(1'b1, 1'b1, 1'b0);
    checks++;
    if (ox0[0] !== 10'd316 || oov !== 2'b11) begin
      errors++;
      $display("FAIL back_to_back: got x0=%0d ov=%b want x0=316 ov=11", ox0[0], oov);
    end
    run_frame(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_edge_x();
    for (int n = 0; n < 200 && m_x[0] != XMAX; n++) run_frame(1'b1, 1'b0, 1'b0);
    checks++;
    if (ox0[0] !== 10'd624) begin
      errors++;
      $display("FAIL edge_x_reach: got x0=%0d want 624", ox0[0]);
    end
    run_frame(1'b1, 1'b0, 1'b1);
    checks++;
    if (ox0[0] !== 10'd622) begin
      errors++;
      $display("FAIL edge_x_return: got x0=%0d want 622", ox0[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      run_frame($urandom_range(9) < 7, $urandom_range(9) == 0, 1'($urandom_range(1)));
    end
  endtask

  task automatic test_reset_mid_update();
    @(negedge clk);
    enable = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({ox0[0], ox1[0], oy0[0], oy1[0]} !== {10'd312, 10'd327, 9'd232, 9'd247}
        || obusy !== 2'b00 || oov !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid: got %0d %0d %0d %0d busy=%b ov=%b want 312 327 232 247 00 00",
               ox0[0], ox1[0], oy0[0], oy1[0], obusy, oov);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 3; n++) run_frame(1'b0, 1'($urandom_range(1)), 1'b0);
    run_frame(1'b1, 1'b0, 1'b0);
    checks++;
    if (ox0[0] !== 10'd314 || oy0[0] !== 9'd234) begin
      errors++;
      $display("FAIL after_reset_move: got x0=%0d y0=%0d want 314 234", ox0[0], oy0[0]);
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_back_to_back();
    test_edge_x();
    test_random();
    test_reset_mid_update();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
